// File: rtl/uart_transmitter.sv
// uart_transmitter: serial UART transmitter with a registered tx line.
// Sends a frame of 1 start bit, DBITS data bits (LSB first) and 1 stop bit.
// Each bit lasts SB_TICK pulses of sample_tick.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
module uart_transmitter #(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic             tx_start,
  input  logic [DBITS-1:0] data_in,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int TICK_W = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
  localparam int BIT_W  = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DBITS - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DBITS-1:0]   shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic               period_end;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  // State register: FSM state, counters, shift register and registered outputs.
  // NOTE: every register here, including the data shift register, is cleared by
  // reset so an aborted frame leaves no stale data behind.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the same pre-edge state.
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic: bit timing, frame sequencing and start acceptance.
  always_comb begin
    // NOTE: hold-value defaults first so no path through the case infers a latch.
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    period_end = sample_tick && (tick_q == TICK_LAST);

    // The tick counter only advances inside a frame and wraps at each period end.
    if (sample_tick && (state_q != ST_IDLE)) begin
      tick_d = period_end ? '0 : tick_q + TICK_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d  = ST_START;
          shreg_d  = data_in;
          tick_d   = '0;
          bit_d    = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      ST_START: begin
        if (period_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (period_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (period_end) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (period_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: tx level for the upcoming state (registered above) and busy flag.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
    tx_busy = (state_q != ST_IDLE);
  end

  assign tx      = tx_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed bench for uart_transmitter with a frame-level
// reference model (bit index derived from ticks elapsed since acceptance).
// Honours UART_TX_PARITY_EN when the bench and design are built with it.
module tb_uart_transmitter;

  localparam int DBITS   = 8;
  localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DBITS + 3;
`else
  localparam int NB = DBITS + 2;
`endif
  localparam int FRAME_CYC = NB * SB_TICK;

  logic       clk_100MHz  = 1'b0;
  logic       reset       = 1'b0;
  logic       sample_tick = 1'b1;
  logic       tx_start    = 1'b0;
  logic [7:0] data_in     = 8'h00;
  logic       tx, tx_busy, tx_done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int done_cnt  = 0;
  int tick_mode = 0;   // 0: tick every clock, 1: every 4th clock, 2: paused

  uart_transmitter #(.DBITS(DBITS), .SB_TICK(SB_TICK)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .sample_tick(sample_tick),
    .tx_start   (tx_start),
    .data_in    (data_in),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  initial forever #5 clk_100MHz = ~clk_100MHz;

  // Baud tick source, changed just after each rising edge.
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge clk_100MHz);
      #1;
      phase = (phase + 1) % 4;
      case (tick_mode)
        0:       sample_tick = 1'b1;
        1:       sample_tick = (phase == 0);
        default: sample_tick = 1'b0;
      endcase
    end
  end

  always @(posedge clk_100MHz) cyc <= cyc + 1;
  always @(negedge clk_100MHz) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a frame is NB bits of SB_TICK ticks each, counted from acceptance.
  bit       m_active = 1'b0;
  bit       m_done   = 1'b0;
  bit [7:0] m_word   = 8'h00;
  int       m_ticks  = 0;

  always @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_ticks  <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (tx_start) begin
          m_active <= 1'b1;
          m_word   <= data_in;
          m_ticks  <= 0;
        end
      end else if (sample_tick) begin
        if (m_ticks + 1 == FRAME_CYC) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end else begin
          m_ticks <= m_ticks + 1;
        end
      end
    end
  end

  function automatic logic model_tx();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_ticks / SB_TICK;
    if (idx == 0) return 1'b0;
    if (idx <= DBITS) return m_word[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == DBITS + 1) return ^m_word;
`endif
    return 1'b1;
  endfunction

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk_100MHz) begin
    check("cycle_model", 32'({tx, tx_busy, tx_done}), 32'({model_tx(), m_active, m_done}));
  end

  task automatic send(input logic [7:0] d, output int acc);
    data_in  = d;
    tx_start = 1'b1;
    @(posedge clk_100MHz);
    #1;
    tx_start = 1'b0;
    acc      = cyc;
  endtask

  // Waits for tx_done; records mid-bit samples (bit k at cycle 16k+8 after acceptance).
  task automatic watch(input int acc, output int done_at, output logic [15:0] mid);
    int rel;
    done_at = -1;
    mid     = '0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk_100MHz);
      rel = cyc - acc;
      if (tick_mode == 0 && rel % SB_TICK == SB_TICK / 2 && rel / SB_TICK < 16)
        mid[rel / SB_TICK] = tx;
      if (tx_done === 1'b1) begin
        done_at = rel;
        break;
      end
    end
    @(posedge clk_100MHz);
    #1;
  endtask

  // Run lengths of constant tx level from acceptance up to (excluding) the tx_done cycle.
  task automatic watch_runs(output int runs[8], output int nruns, output bit seen);
    logic cur;
    int   len;
    nruns = 0;
    seen  = 1'b0;
    cur   = 1'b0;
    len   = 0;
    for (int i = 0; i < 8; i++) runs[i] = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk_100MHz);
      if (tx_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (len == 0 || tx === cur) len++;
      else begin
        if (nruns < 8) runs[nruns] = len;
        nruns++;
        len = 1;
      end
      cur = tx;
    end
    if (nruns < 8) runs[nruns] = len;
    nruns++;
    @(posedge clk_100MHz);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc, done_at, d0, nruns, changes;
    logic [15:0] mid;
    int          runs[8];
    bit          seen;
    logic        hold_tx, hold_busy;

    // Reset state
    #2 reset = 1'b1;
    #1;
    check("reset_tx", 32'(tx), 32'(1));
    check("reset_busy", 32'(tx_busy), 32'(0));
    check("reset_done", 32'(tx_done), 32'(0));
    repeat (3) @(posedge clk_100MHz);
    #1 reset = 1'b0;

    // 0xA5 accepted on the first edge after reset release
    send(8'hA5, acc);
    check("accept_after_reset_busy", 32'(tx_busy), 32'(1));
    check("accept_after_reset_tx", 32'(tx), 32'(0));
    watch(acc, done_at, mid);
    check("a5_done_cycle", 32'(done_at), 32'(FRAME_CYC));
`ifdef UART_TX_PARITY_EN
    check("a5_bits", 32'(mid), 32'h054A);
`else
    check("a5_bits", 32'(mid), 32'h034A);
`endif

    // 0x07: odd number of ones
    send(8'h07, acc);
    watch(acc, done_at, mid);
`ifdef UART_TX_PARITY_EN
    check("07_bits", 32'(mid), 32'h060E);
`else
    check("07_bits", 32'(mid), 32'h020E);
`endif

    // tx_start held high: back-to-back frames, data changed mid-frame
    d0 = done_cnt;
    data_in  = 8'h55;
    tx_start = 1'b1;
    @(posedge clk_100MHz);
    #1;
    repeat (20) @(posedge clk_100MHz);
    #1 data_in = 8'hAA;
    done_at = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_100MHz);
      if (tx_done === 1'b1) begin
        done_at = n;
        break;
      end
    end
    check("b2b_first_done_seen", 32'(done_at >= 0), 32'(1));
    check("b2b_gap_busy_low", 32'(tx_busy), 32'(0));
    @(posedge clk_100MHz);
    #1;
    acc = cyc;
    @(negedge clk_100MHz);
    check("b2b_second_accepted", 32'(tx_busy), 32'(1));
    @(posedge clk_100MHz);
    #1 tx_start = 1'b0;
    watch(acc, done_at, mid);
    check("b2b_second_done_cycle", 32'(done_at), 32'(FRAME_CYC));
    repeat (20) @(posedge clk_100MHz);
    #1;
    check("b2b_done_pulses", 32'(done_cnt - d0), 32'(2));
    check("b2b_idle_after", 32'(tx_busy), 32'(0));

    // tx_start pulsed mid-frame with 0xFF, then data_in scrambled
    d0 = done_cnt;
    send(8'h12, acc);
    repeat (40) @(posedge clk_100MHz);
    #1;
    data_in  = 8'hFF;
    tx_start = 1'b1;
    @(posedge clk_100MHz);
    #1 tx_start = 1'b0;
    repeat (20) begin
      @(posedge clk_100MHz);
      #1 data_in = 8'($urandom);
    end
    watch(acc, done_at, mid);
    check("ignore_start_done_cycle", 32'(done_at), 32'(FRAME_CYC));
    repeat (20) @(posedge clk_100MHz);
    #1;
    check("ignore_start_one_done", 32'(done_cnt - d0), 32'(1));

    // Reset during the 4th data bit of 0x96
    d0 = done_cnt;
    send(8'h96, acc);
    repeat (72) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    check("bit3_before_reset", 32'(tx), 32'(0));
    #2 reset = 1'b1;
    #1;
    check("abort_tx_high", 32'(tx), 32'(1));
    check("abort_busy_low", 32'(tx_busy), 32'(0));
    check("abort_done_low", 32'(tx_done), 32'(0));
    repeat (3) @(posedge clk_100MHz);
    #1 reset = 1'b0;
    send(8'h3C, acc);
    watch(acc, done_at, mid);
    check("abort_no_extra_done", 32'(done_cnt - d0), 32'(1));
    check("post_reset_3c_done", 32'(done_at), 32'(FRAME_CYC));
`ifdef UART_TX_PARITY_EN
    check("post_reset_3c_bits", 32'(mid), 32'h0478);
`else
    check("post_reset_3c_bits", 32'(mid), 32'h0278);
`endif

    // sample_tick every 4th clock: 0x81 bit periods of 64 clocks
    tick_mode = 1;
    @(posedge clk_100MHz);
    #1;
    send(8'h81, acc);
    watch_runs(runs, nruns, seen);
    check("slow_done_seen", 32'(seen), 32'(1));
    check("slow_d0_len", 32'(runs[1]), 32'(64));
    check("slow_zero_run_len", 32'(runs[2]), 32'(384));
`ifdef UART_TX_PARITY_EN
    check("slow_d7_len", 32'(runs[3]), 32'(64));
    check("slow_parity_len", 32'(runs[4]), 32'(64));
`else
    check("slow_d7_stop_len", 32'(runs[3]), 32'(128));
`endif

    // Paused sample_tick mid-frame holds tx and busy
    send(8'h0F, acc);
    repeat (150) @(posedge clk_100MHz);
    #1 tick_mode = 2;
    @(posedge clk_100MHz);
    #2;
    hold_tx   = tx;
    hold_busy = tx_busy;
    changes   = 0;
    repeat (40) begin
      @(negedge clk_100MHz);
      if (tx !== hold_tx || tx_busy !== hold_busy) changes++;
    end
    check("pause_stable", 32'(changes), 32'(0));
    check("pause_busy", 32'(hold_busy), 32'(1));
    tick_mode = 1;
    watch(acc, done_at, mid);
    check("pause_done_seen", 32'(done_at > 0), 32'(1));

    tick_mode = 0;
    repeat (5) @(posedge clk_100MHz);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
